// File: rtl/score_bcd_converter_pkg.sv
// Shared constants and state encoding for the score binary-to-BCD converter.
// Imported by the converter top and by the per-digit adjust cell.
package score_bcd_converter_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_e;

   localparam int         BCD_W          = 4;
   localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
   localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;
   localparam logic [3:0] BCD_NINE       = 4'h9;

endpackage

// File: rtl/bcd_digit_adj.sv
// Combinational shift-and-add-3 correction for one BCD nibble.
// Adds 3 when the nibble is 5 or more, so the following left shift carries into the next digit.
module bcd_digit_adj
   import score_bcd_converter_pkg::*;
(
   input  logic [BCD_W-1:0] digit_i,
   output logic [BCD_W-1:0] digit_o
);

   assign digit_o = (digit_i >= BCD_ADJ_THRESH) ? (digit_i + BCD_ADJ_ADD) : digit_i;

endmodule

// File: rtl/score_bcd_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3) feeding the seven-segment display driver.
// One conversion per start handshake; result and overflow flag are registered and held until the next one.
module score_bcd_converter
   import score_bcd_converter_pkg::*;
#(
   parameter int BIN_W  = 11,
   parameter int DIGITS = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [BIN_W-1:0]          bin_in,
   output logic                      busy,
   output logic                      done,
   output logic [BCD_W*DIGITS-1:0]   bcd_out,
   output logic                      overflow
);

   localparam int SCR_W = BCD_W * (DIGITS + 1);
   localparam int OUT_W = BCD_W * DIGITS;
   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam logic [OUT_W-1:0] ALL_NINES = {DIGITS{BCD_NINE}};

   if (BIN_W < 1 || DIGITS < 1) begin : g_bad_params
      $error("score_bcd_converter: BIN_W and DIGITS must both be at least 1");
   end

   state_e             state_q;
   logic               busy_q;
   logic               done_q;
   logic               ovf_q;
   logic               sticky_q;
   logic [OUT_W-1:0]   bcd_q;
   logic [SCR_W-1:0]   scr_q;
   logic [BIN_W-1:0]   bin_q;
   logic [CNT_W-1:0]   cnt_q;

   logic [SCR_W-1:0]   scr_adj;
   logic [SCR_W-1:0]   scr_d;
   logic [BIN_W-1:0]   bin_d;
   logic               sticky_d;
   logic               ovf_d;

   // The top nibble is a guard digit: anything landing there means the value needs more than DIGITS digits.
   for (genvar g = 0; g < DIGITS + 1; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .digit_i (scr_q[g*BCD_W +: BCD_W]),
         .digit_o (scr_adj[g*BCD_W +: BCD_W])
      );
   end

   // Bits falling off the guard nibble are remembered so very wide inputs still flag overflow.
   always_comb begin
      scr_d    = {scr_adj[SCR_W-2:0], bin_q[BIN_W-1]};
      bin_d    = bin_q << 1;
      sticky_d = sticky_q | scr_adj[SCR_W-1];
      ovf_d    = sticky_d | (scr_d[SCR_W-1 -: BCD_W] != '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
         sticky_q <= 1'b0;
         bcd_q    <= '0;
         scr_q    <= '0;
         bin_q    <= '0;
         cnt_q    <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  bin_q    <= bin_in;
                  scr_q    <= '0;
                  sticky_q <= 1'b0;
                  cnt_q    <= CNT_W'(BIN_W);
                  busy_q   <= 1'b1;
                  state_q  <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               scr_q    <= scr_d;
               bin_q    <= bin_d;
               sticky_q <= sticky_d;
               cnt_q    <= cnt_q - CNT_W'(1);
               // Last shift: publish the result on the same edge that returns to idle.
               if (cnt_q == CNT_W'(1)) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  ovf_q   <= ovf_d;
                  bcd_q   <= ovf_d ? ALL_NINES : scr_d[OUT_W-1:0];
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign bcd_out  = bcd_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_score_bcd_converter.sv
// Self-checking bench for score_bcd_converter: default 11-bit/4-digit instance plus a 14-bit instance
// that exercises overflow saturation; results are scoreboarded against a decimal reference model.
module tb_score_bcd_converter;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [10:0] binIn;
   logic        busy;
   logic        done;
   logic [15:0] bcd;
   logic        ovf;

   logic        startB;
   logic [13:0] binInB;
   logic        busyB;
   logic        doneB;
   logic [15:0] bcdB;
   logic        ovfB;

   int checks = 0;
   int fails  = 0;

   logic [16:0] sbA[$];
   logic [16:0] sbB[$];
   logic [16:0] expA;
   logic [16:0] expB;

   score_bcd_converter #(.BIN_W(11), .DIGITS(4)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .bin_in   (binIn),
      .busy     (busy),
      .done     (done),
      .bcd_out  (bcd),
      .overflow (ovf)
   );

   score_bcd_converter #(.BIN_W(14), .DIGITS(4)) u_dut14 (
      .clk      (clk),
      .rst      (rst),
      .start    (startB),
      .bin_in   (binInB),
      .busy     (busyB),
      .done     (doneB),
      .bcd_out  (bcdB),
      .overflow (ovfB)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: {overflow, packed BCD} computed with plain decimal arithmetic.
   function automatic logic [16:0] refBcd(input int v);
      if (v > 9999) return {1'b1, 16'h9999};
      return {1'b0, 4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   // Scoreboard monitors: a done pulse must match the oldest pending expectation.
   always @(negedge clk) begin
      if (!rst) begin
         checkOutput("doneBusyExclA", {31'b0, done & busy}, 32'd0);
         if (sbA.size() == 0) begin
            checkOutput("spuriousDoneA", {31'b0, done}, 32'd0);
         end else if (done) begin
            expA = sbA.pop_front();
            checkOutput("resultA", {15'b0, ovf, bcd}, {15'b0, expA});
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         checkOutput("doneBusyExclB", {31'b0, doneB & busyB}, 32'd0);
         if (sbB.size() == 0) begin
            checkOutput("spuriousDoneB", {31'b0, doneB}, 32'd0);
         end else if (doneB) begin
            expB = sbB.pop_front();
            checkOutput("resultB", {15'b0, ovfB, bcdB}, {15'b0, expB});
         end
      end
   end

   // Start one conversion on the default instance and wait (bounded) for its done pulse.
   task automatic applyStimulus(input int v, input bit checkTiming);
      int n;
      int busyCycles;
      @(negedge clk);
      binIn = 11'(v);
      start = 1'b1;
      sbA.push_back(refBcd(v));
      @(posedge clk);
      #1;
      start = 1'b0;
      binIn = 11'($urandom);
      n = 0;
      busyCycles = (busy === 1'b1) ? 1 : 0;
      while (done !== 1'b1 && n < 40) begin
         @(posedge clk);
         #1;
         n++;
         if (busy === 1'b1) busyCycles++;
      end
      if (checkTiming) begin
         checkOutput("latencyA", n, 11);
         checkOutput("busyCyclesA", busyCycles, 11);
      end else if (n >= 40) begin
         checkOutput("timeoutA", n, 11);
      end
   endtask

   task automatic applyStimulusB(input int v);
      int n;
      @(negedge clk);
      binInB = 14'(v);
      startB = 1'b1;
      sbB.push_back(refBcd(v));
      @(posedge clk);
      #1;
      startB = 1'b0;
      n = 0;
      while (doneB !== 1'b1 && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput("latencyB", n, 14);
   endtask

   initial begin
      int sweep[7] = '{9, 10, 99, 100, 999, 1000, 1999};
      int cyc;
      int lastAccept;
      int n;

      rst    = 1'b1;
      start  = 1'b0;
      binIn  = '0;
      startB = 1'b0;
      binInB = '0;
      repeat (2) @(negedge clk);
      checkOutput("resetBusy", {31'b0, busy}, 32'd0);
      checkOutput("resetDone", {31'b0, done}, 32'd0);
      checkOutput("resetBcd", {16'b0, bcd}, 32'd0);
      checkOutput("resetOvf", {31'b0, ovf}, 32'd0);
      checkOutput("resetBcdB", {15'b0, ovfB, bcdB}, 32'd0);
      rst = 1'b0;

      $display("[TB] zero and full-scale conversions");
      applyStimulus(0, 1'b1);
      @(posedge clk);
      #1;
      checkOutput("donePulseOnce", {31'b0, done}, 32'd0);
      checkOutput("holdBcd", {15'b0, ovf, bcd}, 32'd0);
      applyStimulus(2047, 1'b1);

      $display("[TB] decade boundary sweep");
      foreach (sweep[i]) applyStimulus(sweep[i], 1'b1);

      $display("[TB] exhaustive 0..2047");
      for (int v = 0; v < 2048; v++) applyStimulus(v, 1'b0);

      $display("[TB] start held high with changing bin_in");
      cyc = 0;
      lastAccept = -1;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         start = 1'b1;
         binIn = 11'($urandom_range(0, 2047));
         if (busy === 1'b0) begin
            sbA.push_back(refBcd(int'(binIn)));
            if (lastAccept >= 0) checkOutput("startPeriod", cyc - lastAccept, 12);
            lastAccept = cyc;
         end
         cyc++;
      end
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (sbA.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checkOutput("drainA", sbA.size(), 0);

      $display("[TB] reset mid-conversion");
      applyStimulus(1999, 1'b1);
      @(negedge clk);
      binIn = 11'd1234;
      start = 1'b1;
      sbA.push_back(refBcd(1234));
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      sbA.delete();
      checkOutput("abortBcd", {15'b0, ovf, bcd}, 32'd0);
      checkOutput("abortBusy", {31'b0, busy}, 32'd0);
      checkOutput("abortDone", {31'b0, done}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      checkOutput("noDoneAfterAbort", {15'b0, ovf, bcd}, 32'd0);
      applyStimulus(1234, 1'b1);
      #1;
      checkOutput("after1234", {16'b0, bcd}, 32'h1234);

      $display("[TB] 14-bit instance overflow saturation");
      applyStimulusB(12345);
      #1;
      checkOutput("ovfSat", {15'b0, ovfB, bcdB}, {15'b0, 1'b1, 16'h9999});
      applyStimulusB(9999);
      #1;
      checkOutput("noOvf9999", {15'b0, ovfB, bcdB}, {15'b0, 1'b0, 16'h9999});
      applyStimulusB(10000);
      applyStimulusB(16383);
      applyStimulusB(4321);

      repeat (3) @(negedge clk);
      checkOutput("drainB", sbB.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
